// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Source indices name the fixed requester slots wired at the top level.
package rf_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_MDU = 2;

    // Next round-robin pointer after granting source g out of n.
    function automatic int rr_next(input int g, input int n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Round-robin one-hot grant: first requester at or after ptr, wrapping modulo N.
// Purely combinational; the pointer is owned and updated by the parent.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic found;

    // Two passes: upper segment [ptr, N-1] first, then the wrapped segment [0, ptr-1].
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin share of the register-file write port plus a busy scoreboard for
// long-latency destinations; one cycle from handshake to the write port.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_SRC-1:0]              src_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]   src_addr,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data,
    output logic [NUM_SRC-1:0]              src_ready,
    input  logic                            wb_hold,
    output logic                            rf_wr_en,
    output logic [REG_ADDR_W-1:0]           rf_wr_addr,
    output logic [DATA_WIDTH-1:0]           rf_wr_data,
    input  logic                            sb_set_en,
    input  logic [REG_ADDR_W-1:0]           sb_set_addr,
    input  logic [REG_ADDR_W-1:0]           rs1_addr,
    input  logic [REG_ADDR_W-1:0]           rs2_addr,
    output logic                            rs1_busy,
    output logic                            rs2_busy,
    output logic                            sb_err
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  rf_wr_en_q, rf_wr_en_d;
    logic [REG_ADDR_W-1:0] rf_wr_addr_q, rf_wr_addr_d;
    logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  sb_err_q, sb_err_d;

    logic [NUM_SRC-1:0]    gnt;
    logic [PTR_W-1:0]      gnt_idx;
    logic                  any_gnt;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  clr_hit;

    rr_arbiter #(
        .N     (NUM_SRC),
        .PTR_W (PTR_W)
    ) u_rr (
        .req (src_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    assign src_ready = (reset || wb_hold) ? '0 : gnt;
    assign any_gnt   = |src_ready;

    always_comb begin
        gnt_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_ready[i]) begin
                gnt_idx  = PTR_W'(i);
                sel_addr = src_addr[REG_ADDR_W*i +: REG_ADDR_W];
                sel_data = src_data[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // An x0 request is still accepted (and moves the pointer) but never writes.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        rf_wr_en_d   = 1'b0;
        rf_wr_addr_d = rf_wr_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        if (any_gnt) begin
            rr_ptr_d     = PTR_W'(rr_next(int'(gnt_idx), NUM_SRC));
            rf_wr_en_d   = (sel_addr != '0);
            rf_wr_addr_d = sel_addr;
            rf_wr_data_d = sel_data;
        end
    end

    // The clear rides on the write that commits this cycle; a same-cycle set wins.
    always_comb begin
        busy_d   = busy_q;
        sb_err_d = sb_err_q;
        clr_hit  = rf_wr_en_q && (rf_wr_addr_q == sb_set_addr);
        if (rf_wr_en_q) begin
            busy_d[rf_wr_addr_q] = 1'b0;
        end
        if (sb_set_en && (sb_set_addr != '0)) begin
            if (busy_q[sb_set_addr] && !clr_hit) begin
                sb_err_d = 1'b1;
            end
            busy_d[sb_set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
            busy_q       <= '0;
            sb_err_q     <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_wr_addr_q <= rf_wr_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            busy_q       <= busy_d;
            sb_err_q     <= sb_err_d;
        end
    end

    assign rf_wr_en   = rf_wr_en_q;
    assign rf_wr_addr = rf_wr_addr_q;
    assign rf_wr_data = rf_wr_data_q;
    assign rs1_busy   = busy_q[rs1_addr];
    assign rs2_busy   = busy_q[rs2_addr];
    assign sb_err     = sb_err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, round-robin order, x0 writes,
// scoreboard set/clear/error, wb_hold and asynchronous reset mid-stream.
module tb_rf_wb_arbiter;

    localparam int DW = 32;
    localparam int NS = 3;

    logic           clk;
    logic           reset;
    logic [NS-1:0]  src_valid;
    logic [NS*5-1:0] src_addr;
    logic [NS*DW-1:0] src_data;
    logic [NS-1:0]  src_ready;
    logic           wb_hold;
    logic           rf_wr_en;
    logic [4:0]     rf_wr_addr;
    logic [DW-1:0]  rf_wr_data;
    logic           sb_set_en;
    logic [4:0]     sb_set_addr;
    logic [4:0]     rs1_addr;
    logic [4:0]     rs2_addr;
    logic           rs1_busy;
    logic           rs2_busy;
    logic           sb_err;

    int total = 0;
    int bad   = 0;

    rf_wb_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS)) dut (
        .clk         (clk),
        .reset       (reset),
        .src_valid   (src_valid),
        .src_addr    (src_addr),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .wb_hold     (wb_hold),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .sb_err      (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        src_valid = '0;
        wb_hold   = 1'b0;
        sb_set_en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset       = 1'b0;
        src_valid   = '0;
        src_addr    = '0;
        src_data    = '0;
        wb_hold     = 1'b0;
        sb_set_en   = 1'b0;
        sb_set_addr = '0;
        rs1_addr    = 5'd0;
        rs2_addr    = 5'd0;
        #2;
        reset = 1'b1;
        step();
        total++; if (rf_wr_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b want=0", rf_wr_en); end
        total++; if (rf_wr_addr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", rf_wr_addr); end
        total++; if (rf_wr_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", rf_wr_data); end
        total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL reset_sb_err got=%b want=0", sb_err); end
        src_valid = 3'b111;
        #1;
        total++; if (src_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b want=000", src_ready); end
        src_valid = '0;
        #2;
        reset = 1'b0;
        step();
        // first transfer
        src_valid = 3'b001;
        src_addr  = {5'd0, 5'd0, 5'd5};
        src_data  = {32'h0, 32'h0, 32'hDEADBEEF};
        #1;
        total++; if (src_ready !== 3'b001) begin bad++; $display("FAIL first_ready got=%b want=001", src_ready); end
        step();
        src_valid = '0;
        total++; if (rf_wr_en !== 1'b1) begin bad++; $display("FAIL first_en got=%b want=1", rf_wr_en); end
        total++; if (rf_wr_addr !== 5'd5) begin bad++; $display("FAIL first_addr got=%0d want=5", rf_wr_addr); end
        total++; if (rf_wr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL first_data got=%h want=deadbeef", rf_wr_data); end
    endtask

    task automatic test_round_robin;
        logic [NS-1:0] exp_rdy;
        do_reset();
        src_addr  = {5'd3, 5'd2, 5'd1};
        src_data  = {32'h103, 32'h102, 32'h101};
        src_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_rdy = 3'b001 << (k % 3);
            #1;
            total++; if (src_ready !== exp_rdy) begin bad++; $display("FAIL rr_ready[%0d] got=%b want=%b", k, src_ready, exp_rdy); end
            step();
            total++;
            if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'((k % 3) + 1) || rf_wr_data !== 32'(32'h101 + (k % 3))) begin
                bad++;
                $display("FAIL rr_write[%0d] got en=%b addr=%0d data=%h want en=1 addr=%0d", k, rf_wr_en, rf_wr_addr, rf_wr_data, (k % 3) + 1);
            end
        end
        src_valid = '0;
        step();
        total++; if (rf_wr_en !== 1'b0 || rf_wr_addr !== 5'd3) begin bad++; $display("FAIL rr_idle got en=%b addr=%0d want en=0 addr=3", rf_wr_en, rf_wr_addr); end
    endtask

    task automatic test_x0_write;
        src_valid = 3'b010;
        src_addr  = {5'd0, 5'd0, 5'd0};
        src_data  = {32'h0, 32'h1234, 32'h0};
        #1;
        total++; if (src_ready !== 3'b010) begin bad++; $display("FAIL x0_ready got=%b want=010", src_ready); end
        step();
        src_valid = '0;
        total++; if (rf_wr_en !== 1'b0) begin bad++; $display("FAIL x0_en got=%b want=0", rf_wr_en); end
    endtask

    task automatic test_scoreboard_clear;
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd7;
        step();
        sb_set_en = 1'b0;
        rs1_addr  = 5'd7;
        rs2_addr  = 5'd7;
        #1;
        total++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin bad++; $display("FAIL sb_set7 got rs1=%b rs2=%b want 1 1", rs1_busy, rs2_busy); end
        src_valid = 3'b100;
        src_addr  = {5'd7, 5'd0, 5'd0};
        src_data  = {32'h77, 32'h0, 32'h0};
        #1;
        total++; if (src_ready !== 3'b100) begin bad++; $display("FAIL sb_wr_ready got=%b want=100", src_ready); end
        step();
        src_valid = '0;
        total++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd7) begin bad++; $display("FAIL sb_wr got en=%b addr=%0d want en=1 addr=7", rf_wr_en, rf_wr_addr); end
        total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL sb_busy_during_write got=%b want=1", rs1_busy); end
        step();
        total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL sb_cleared got=%b want=0", rs1_busy); end
        // set coincident with the committing write of the same register
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd7;
        step();
        sb_set_en = 1'b0;
        src_valid = 3'b100;
        #1;
        total++; if (src_ready !== 3'b100) begin bad++; $display("FAIL sb_wr2_ready got=%b want=100", src_ready); end
        step();
        src_valid   = '0;
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd7;
        total++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd7) begin bad++; $display("FAIL sb_wr2 got en=%b addr=%0d want en=1 addr=7", rf_wr_en, rf_wr_addr); end
        step();
        sb_set_en = 1'b0;
        total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL sb_set_wins got=%b want=1", rs1_busy); end
        total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL sb_set_wins_err got=%b want=0", sb_err); end
    endtask

    task automatic test_scoreboard_err;
        rs1_addr    = 5'd9;
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd9;
        step();
        total++; if (sb_err !== 1'b0 || rs1_busy !== 1'b1) begin bad++; $display("FAIL sb_first9 got err=%b busy=%b want 0 1", sb_err, rs1_busy); end
        step();
        sb_set_en = 1'b0;
        total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL sb_double9 got=%b want=1", sb_err); end
        repeat (3) step();
        total++; if (sb_err !== 1'b1 || rs1_busy !== 1'b1) begin bad++; $display("FAIL sb_sticky got err=%b busy=%b want 1 1", sb_err, rs1_busy); end
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd0;
        step();
        sb_set_en = 1'b0;
        rs1_addr  = 5'd0;
        #1;
        total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL sb_x0 got=%b want=0", rs1_busy); end
    endtask

    task automatic test_hold_and_reset;
        // move the pointer to source 1 first
        src_addr  = {5'd3, 5'd2, 5'd1};
        src_data  = {32'h303, 32'h302, 32'h301};
        src_valid = 3'b001;
        step();
        src_valid = 3'b111;
        wb_hold   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (src_ready !== 3'b000) begin bad++; $display("FAIL hold_ready[%0d] got=%b want=000", k, src_ready); end
            step();
            total++; if (rf_wr_en !== 1'b0) begin bad++; $display("FAIL hold_en[%0d] got=%b want=0", k, rf_wr_en); end
        end
        wb_hold = 1'b0;
        #1;
        total++; if (src_ready !== 3'b010) begin bad++; $display("FAIL hold_ptr got=%b want=010", src_ready); end
        step();
        total++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd2) begin bad++; $display("FAIL hold_resume got en=%b addr=%0d want en=1 addr=2", rf_wr_en, rf_wr_addr); end
        rs1_addr = 5'd9;
        rs2_addr = 5'd7;
        #2;
        reset = 1'b1;
        #1;
        total++; if (rf_wr_en !== 1'b0 || rf_wr_addr !== 5'd0 || rf_wr_data !== 32'h0) begin bad++; $display("FAIL arst_out got en=%b addr=%0d data=%h want 0", rf_wr_en, rf_wr_addr, rf_wr_data); end
        total++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || sb_err !== 1'b0) begin bad++; $display("FAIL arst_sb got b9=%b b7=%b err=%b want 0", rs1_busy, rs2_busy, sb_err); end
        total++; if (src_ready !== 3'b000) begin bad++; $display("FAIL arst_ready got=%b want=000", src_ready); end
        step();
        reset = 1'b0;
        #1;
        total++; if (src_ready !== 3'b001) begin bad++; $display("FAIL arst_restart got=%b want=001", src_ready); end
        step();
        src_valid = '0;
        total++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd1 || rf_wr_data !== 32'h301) begin bad++; $display("FAIL arst_first got en=%b addr=%0d data=%h want 1 1 301", rf_wr_en, rf_wr_addr, rf_wr_data); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_x0_write();
        test_scoreboard_clear();
        test_scoreboard_err();
        test_hold_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single synchronous write port among NUM_SRC writeback sources: ALU, load unit and multi-cycle unit.
- Each source uses a valid/ready handshake. Arbitration is round-robin, and the winning request is registered onto the register-file write port.
- Keeps a 32-entry busy scoreboard for long-latency destinations so that issue logic can stall on RAW/WAW hazards.
- Sits between the execute/memory stages and the register file write port.

Parameters:
- DATA_WIDTH, 32, width of the register data.
- NUM_SRC, 3, number of writeback requesters (2..8).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- src_valid  in  NUM_SRC  per-source write request.
- src_addr  in  NUM_SRC*5  destination register per source; source i uses bits [5i+4:5i].
- src_data  in  NUM_SRC*DATA_WIDTH  write data per source; source i uses slice i.
- src_ready  out  NUM_SRC  one-hot grant; combinational from src_valid, wb_hold and rr_ptr.
- wb_hold  in  1  when high, no grants are issued.
- rf_wr_en  out  1  register file write enable (registered).
- rf_wr_addr  out  5  register file write address (registered).
- rf_wr_data  out  DATA_WIDTH  register file write data (registered).
- sb_set_en  in  1  issue logic marks a destination register busy.
- sb_set_addr  in  5  register to mark busy.
- rs1_addr, rs2_addr  in  5 each  scoreboard query addresses.
- rs1_busy, rs2_busy  out  1 each  combinational busy[rsN_addr]; always 0 for x0.
- sb_err  out  1  sticky flag: sb_set_en was asserted on an already-busy register.

Behaviour:
- Reset (asynchronous, immediate): rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, busy=0, rr_ptr=0, sb_err=0. src_ready=0 while reset is high.
- Handshake: a transfer occurs when src_valid[i] and src_ready[i] are both high. At most one src_ready bit is high per cycle. src_ready never depends on src_data.
- Source obligations: once valid is raised, src_addr and src_data stay stable until the transfer. The arbiter does not check this.
- Arbitration: scan the sources starting at rr_ptr, wrapping modulo NUM_SRC. The first source with valid=1 is granted.
  - After a grant to source g, rr_ptr becomes (g+1) mod NUM_SRC.
  - With no grant, rr_ptr holds.
- wb_hold=1: src_ready=0, rr_ptr holds. On the next edge rf_wr_en=0.
- Output register: rf_wr_en, rf_wr_addr and rf_wr_data are registered.
  - A grant in cycle N gives rf_wr_en=1 with the granted addr/data in cycle N+1.
  - The register file commits at the end of N+1, so latency is 1 cycle from handshake to the port.
  - With no grant, rf_wr_en=0 in N+1; addr/data hold their last values.
- x0 writes: a request with addr=0 is still handshaken (accepted), but produces rf_wr_en=0 in N+1.
- Scoreboard, busy[31:1] (busy[0] is constant 0):
  - Set: sb_set_en with sb_set_addr≠0 sets the bit at the edge.
  - Clear: rf_wr_en=1 with rf_wr_addr=a clears busy[a] at the same edge that commits the register file write. The read-after-edge therefore sees the new value and no busy bit.
  - Set and clear of the same register in the same cycle: set wins.
  - Set on a register that is already busy and not clearing that cycle: sb_err<=1 (sticky until reset). The bit stays 1.
  - sb_set_addr=0 is ignored.
- Any source may write any register. Writes to non-busy registers are legal and do not touch the scoreboard.
- Reset mid-transfer: any pending output write is discarded (rf_wr_en forced to 0) and all busy bits clear.

Decomposition:
- Shared package/header: REG_ADDR_W=5, NUM_REGS=32, and source index constants SRC_ALU=0, SRC_LSU=1, SRC_MDU=2.
- One sub-module: rr_arbiter (parameter N; inputs req, ptr; output one-hot gnt; combinational). It is instantiated once, and rr_ptr stays in the parent.

Test Plan:
1. Reset with all inputs idle -> all outputs 0. Then src0 valid, addr=5, data=0xDEADBEEF -> src_ready=001 in the same cycle; next cycle rf_wr_en=1, addr=5, data=0xDEADBEEF.
2. All 3 sources held valid for 6 cycles (addrs 1/2/3) -> grant order 0,1,2,0,1,2; rf_wr_addr sequence 1,2,3,1,2,3, each lagging its grant by 1 cycle.
3. src1 valid, addr=0, data=0x1234 -> src_ready[1]=1, rf_wr_en stays 0 in the following cycle.
4. sb_set addr=7 -> rs1_addr=7 reports busy=1. src2 writes addr 7 -> busy stays 1 through the cycle rf_wr_en=1, then reads 0 after that edge. Repeat with sb_set addr=7 coincident with the write of 7 -> busy remains 1, sb_err stays 0.
5. sb_set addr=9 twice with no intervening write -> sb_err=1 after the second edge and stays 1 until reset. sb_set addr=0 -> rs1_busy(0)=0.
6. wb_hold=1 with all sources valid for 3 cycles -> src_ready=000 and rr_ptr unchanged. Assert reset mid-stream while rf_wr_en=1 -> outputs and busy bits go to 0 immediately; after release, arbitration restarts at source 0.
